main_memory_responder: RTL and testbench
========================================

// Module: main_memory_responder
// PURPOSE
//  Backing-memory responder on the far side of the cache controller's evict/allocate path.
//  Accepts one 512-bit line request at a time: a line fill (read) or a writeback (write).
//  Returns the response after a fixed MEM_DELAY latency.
//  Unwritten lines return the fill pattern the cache expects: word i = block_base + 4*i.
// PARAMETERS
//  MEM_DELAY     20   cycles from request acceptance to resp_valid; legal range 1..31
//  LINE_BITS     512  line width in bits (16 x 32-bit words)
//  INDEX_BITS    8    line-store index, taken from addr[13:6]; 256 lines
//  CNT_BITS      16   width of the statistics counters
// PORTS
//  clk         in   1    clock, rising edge
//  rst         in   1    asynchronous, active-high reset
//  req_valid   in   1    request present
//  req_ready   out  1    responder can accept a request
//  req_we      in   1    0 = line fill (read), 1 = writeback (write)
//  req_addr    in   32   byte address; bits [5:0] are ignored
//  req_wdata   in   512  writeback line; word i occupies bits [32*i+31:32*i]
//  resp_valid  out  1    response present
//  resp_ready  in   1    consumer accepts the response
//  resp_we     out  1    echo of req_we (1 = write acknowledge)
//  resp_addr   out  32   echo of the block-aligned request address ({addr[31:6],6'b0})
//  resp_rdata  out  512  fill data on reads; all zeros on write acknowledges
//  busy        out  1    high in WAIT or RESP
//  rd_count    out  16   number of completed reads, saturating
//  wr_count    out  16   number of completed writes, saturating
// BEHAVIOUR
//  States: IDLE -> WAIT -> RESP -> IDLE. req_ready = (state==IDLE). busy = !req_ready.
//  IDLE: on req_valid && req_ready at edge E:
//   - latch we, aligned addr and wdata
//   - clear the delay counter
//   - go to WAIT
//  WAIT: the counter increments each cycle. When the counter reaches MEM_DELAY-1:
//   - go to RESP; resp_valid rises at edge E+MEM_DELAY
//   - on that same edge, reads load resp_rdata and writes commit to the store
//  Store per line: data[512], tag[17:0] = addr[31:14], written flag.
//  Read: if written[idx] && tag[idx]==addr[31:14], return stored data; else return the pattern.
//   - Pattern: word i = base + 4*i, where base = {addr[31:6],6'b0}; 32-bit wrap-around allowed.
//  Write: store wdata, set tag, set written; resp_rdata = 0.
//   - A write to an index holding a different tag overwrites it; the old tag is lost.
//  RESP: resp_valid and all resp_* outputs are held stable until resp_ready is high.
//   - The handshake edge goes to IDLE; resp_valid = 0 and req_ready = 1 the next cycle.
//   - The same edge increments rd_count or wr_count; each saturates at 16'hFFFF.
//  Minimum turnaround: a new request is accepted no earlier than one cycle after the response handshake.
//  req_valid is ignored outside IDLE; no request buffering exists.
//  resp_ready while resp_valid=0 is ignored.
//  A read following a write to the same line returns the written data (the write committed earlier).
//  Reset values:
//   - state = IDLE, req_ready = 1, resp_valid = 0, resp_we = 0
//   - resp_addr = 0, resp_rdata = 0, busy = 0, counters = 0
//   - all written flags = 0; the data/tag arrays need not be cleared
//  Reset mid-operation: the in-flight request is dropped with no response and no store update.
//   - Every line reverts to pattern contents.
// TESTING
//  T1 Read miss: read 0x0000_1040 at edge E -> resp_valid at E+20.
//     Expected: resp_addr=0x0000_1040, word0=0x0000_1040, word15=0x0000_107C, rd_count=1.
//  T2 Write then read: write 0x0000_2000 with word3=0xDEADBEEF.
//     Expected: write ack with rdata=0, then a read returns word3=0xDEADBEEF and word0=0; wr_count=1.
//  T3 Alias: write 0x0000_0080, then read 0x0000_4080 (same index, different tag).
//     Expected: the read returns the pattern word0=0x0000_4080.
//  T4 Backpressure: hold resp_ready=0 for 7 cycles.
//     Expected: resp_* stable; req_valid is ignored; req_ready=0 until 1 cycle after the handshake.
//  T5 Reset mid-WAIT: pulse rst 10 cycles after a write is accepted.
//     Expected: no resp_valid; a read of the same address returns the pattern; counters=0.
//  T6 Wrap: read 0xFFFF_FFC4.
//     Expected: word0=0xFFFF_FFC0, word15=0xFFFF_FFFC; low offset bits are ignored.

Source files
------------

// File: rtl/mem_resp_if.sv
// Line request/response bundle between the cache controller and the
// backing-memory responder.
interface mem_resp_if #(
  parameter int LINE_BITS = 512
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [31:0]          req_addr;
  logic [LINE_BITS-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic                 resp_we;
  logic [31:0]          resp_addr;
  logic [LINE_BITS-1:0] resp_rdata;

  modport master (
    output req_valid, req_we, req_addr,
    output req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_we,
    input  resp_addr, resp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_wdata, resp_ready,
    output req_ready, resp_valid, resp_we,
    output resp_addr, resp_rdata
  );
endinterface

// File: rtl/main_memory_responder.sv
// Fixed-latency backing memory: one line fill or writeback in flight,
// unwritten lines read back as the address-ramp pattern.
module main_memory_responder #(
  parameter int MEM_DELAY  = 20,
  parameter int LINE_BITS  = 512,
  parameter int INDEX_BITS = 8,
  parameter int CNT_BITS   = 16
) (
  input  logic                clk,
  input  logic                rst,
  mem_resp_if.slave           bus,
  output logic                busy,
  output logic [CNT_BITS-1:0] rd_count,
  output logic [CNT_BITS-1:0] wr_count
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 32 - 6 - INDEX_BITS;
  localparam int WORDS    = LINE_BITS / 32;
  localparam logic [4:0] LAST = 5'(MEM_DELAY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t               state;
  logic [4:0]           cnt;
  logic                 lat_we;
  logic [31:0]          lat_addr;
  logic [LINE_BITS-1:0] lat_wdata;

  logic                 req_ready_q;
  logic                 resp_valid_q;
  logic                 resp_we_q;
  logic [31:0]          resp_addr_q;
  logic [LINE_BITS-1:0] resp_rdata_q;

  logic [LINE_BITS-1:0] data_mem [LINES];
  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]     written;

  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0]   tg;
  logic                  hit;
  logic                  done;
  logic                  commit;
  logic [LINE_BITS-1:0]  pattern;
  logic                  unused_low;

  assign unused_low = ^bus.req_addr[5:0];

  assign idx    = lat_addr[6 +: INDEX_BITS];
  assign tg     = lat_addr[31 -: TAG_BITS];
  assign hit    = written[idx] && (tag_mem[idx] == tg);
  assign done   = (state == WAIT) && (cnt == LAST);
  assign commit = done && lat_we;

  // lat_addr is already block aligned, so word 0 is the base itself
  always_comb begin
    pattern = '0;
    for (int i = 0; i < WORDS; i++) begin
      pattern[32*i +: 32] = lat_addr + 32'(4 * i);
    end
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      data_mem[idx] <= lat_wdata;
      tag_mem[idx]  <= tg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_we       <= 1'b0;
      lat_addr     <= '0;
      lat_wdata    <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_we_q    <= 1'b0;
      resp_addr_q  <= '0;
      resp_rdata_q <= '0;
      written      <= '0;
      rd_count     <= '0;
      wr_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.req_valid) begin
            lat_we      <= bus.req_we;
            lat_addr    <= {bus.req_addr[31:6], 6'b0};
            lat_wdata   <= bus.req_wdata;
            cnt         <= '0;
            req_ready_q <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_we_q    <= lat_we;
            resp_addr_q  <= lat_addr;
            if (lat_we) begin
              resp_rdata_q <= '0;
              written[idx] <= 1'b1;
            end else begin
              resp_rdata_q <= hit ? data_mem[idx] : pattern;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            if (resp_we_q) begin
              if (wr_count != '1) wr_count <= wr_count + 1'b1;
            end else begin
              if (rd_count != '1) rd_count <= rd_count + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_we    = resp_we_q;
  assign bus.resp_addr  = resp_addr_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign busy           = ~req_ready_q;

endmodule

// File: tb/tb_main_memory_responder.sv
// Self-checking bench: directed table, hand sequences and random
// traffic against a block-address keyed reference store.
module tb_main_memory_responder;

  localparam int D = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  always #5 clk = ~clk;

  mem_resp_if bus();

  main_memory_responder #(.MEM_DELAY(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .rd_count (rd_count),
    .wr_count (wr_count)
  );

  int checks = 0;
  int errors = 0;
  int exp_rd = 0;
  int exp_wr = 0;

  logic [511:0] mem_m [logic [31:0]];

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] w3in;
    logic [31:0] e0;
    logic [31:0] e3;
    logic [31:0] e15;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm, input logic [511:0] got,
                     input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", nm, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] base);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = base + 32'(4 * i);
    return r;
  endfunction

  // One line per index: a write evicts any other block sharing addr[13:6]
  task automatic model_access(input bit we, input logic [31:0] blk,
                              input logic [511:0] wd,
                              output logic [511:0] r);
    logic [31:0] victims [$];
    if (we) begin
      foreach (mem_m[k])
        if (k[13:6] == blk[13:6] && k != blk) victims.push_back(k);
      foreach (victims[j]) mem_m.delete(victims[j]);
      mem_m[blk] = wd;
      r = '0;
    end else begin
      r = mem_m.exists(blk) ? mem_m[blk] : pat(blk);
    end
  endtask

  task automatic do_txn(input bit we, input logic [31:0] addr,
                        input logic [511:0] wd, input int hold,
                        input string nm, output logic [511:0] got);
    logic [31:0]  blk;
    logic [511:0] exp;
    logic [31:0]  a_hold;
    logic [511:0] d_hold;
    int           early;
    blk = {addr[31:6], 6'b0};
    @(negedge clk);
    chk({nm, " req_ready"}, bus.req_ready, 1);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    bus.resp_ready = (hold == 0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({nm, " busy"}, busy, 1);
    early = 0;
    for (int k = 0; k < D; k++) begin
      if (bus.resp_valid) early++;
      @(negedge clk);
    end
    chk({nm, " early_valid"}, early, 0);
    chk({nm, " resp_valid"}, bus.resp_valid, 1);
    model_access(we, blk, wd, exp);
    chk({nm, " resp_we"}, bus.resp_we, we);
    chk({nm, " resp_addr"}, bus.resp_addr, blk);
    chk({nm, " rdata"}, bus.resp_rdata, exp);
    got    = bus.resp_rdata;
    a_hold = bus.resp_addr;
    d_hold = bus.resp_rdata;
    for (int h = 0; h < hold; h++) begin
      bus.req_valid = 1'b1;
      bus.req_we    = 1'($urandom);
      bus.req_addr  = $urandom;
      @(negedge clk);
      chk({nm, " hold_valid"}, bus.resp_valid, 1);
      chk({nm, " hold_addr"}, bus.resp_addr, a_hold);
      chk({nm, " hold_data"}, bus.resp_rdata, d_hold);
      chk({nm, " hold_rdy"}, bus.req_ready, 0);
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    if (we) exp_wr++;
    else exp_rd++;
    chk({nm, " post_valid"}, bus.resp_valid, 0);
    chk({nm, " post_rdy"}, bus.req_ready, 1);
    chk({nm, " post_busy"}, busy, 0);
    chk({nm, " rd_count"}, rd_count, 16'(exp_rd));
    chk({nm, " wr_count"}, wr_count, 16'(exp_wr));
  endtask

  initial begin
    logic [511:0] wd;
    logic [511:0] got;
    logic [31:0]  a;
    int           seen;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst req_ready", bus.req_ready, 1);
    chk("rst resp_valid", bus.resp_valid, 0);
    chk("rst resp_we", bus.resp_we, 0);
    chk("rst resp_addr", bus.resp_addr, 0);
    chk("rst resp_rdata", bus.resp_rdata, 0);
    chk("rst busy", busy, 0);
    chk("rst counts", {rd_count, wr_count}, 0);
    rst = 1'b0;

    tbl[0] = '{0, 32'h0000_1040, 32'h0, 32'h0000_1040, 32'h0000_104C, 32'h0000_107C};
    tbl[1] = '{1, 32'h0000_2000, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
    tbl[2] = '{0, 32'h0000_2000, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0};
    tbl[3] = '{1, 32'h0000_0080, 32'h1234_5678, 32'h0, 32'h0, 32'h0};
    tbl[4] = '{0, 32'h0000_4080, 32'h0, 32'h0000_4080, 32'h0000_408C, 32'h0000_40BC};
    tbl[5] = '{0, 32'h0000_0080, 32'h0, 32'h0, 32'h1234_5678, 32'h0};
    tbl[6] = '{0, 32'hFFFF_FFC4, 32'h0, 32'hFFFF_FFC0, 32'hFFFF_FFCC, 32'hFFFF_FFFC};

    for (int t = 0; t < 7; t++) begin
      wd = '0;
      wd[127:96] = tbl[t].w3in;
      do_txn(tbl[t].we, tbl[t].addr, wd, t % 2, $sformatf("vec%0d", t), got);
      chk($sformatf("vec%0d w0", t), got[31:0], tbl[t].e0);
      chk($sformatf("vec%0d w3", t), got[127:96], tbl[t].e3);
      chk($sformatf("vec%0d w15", t), got[511:480], tbl[t].e15);
    end

    do_txn(0, 32'h0000_5000, '0, 7, "backpressure", got);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h0000_3000;
    for (int i = 0; i < 16; i++) bus.req_wdata[32*i +: 32] = $urandom;
    @(negedge clk);
    bus.req_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_m.delete();
    exp_rd = 0;
    exp_wr = 0;
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      if (bus.resp_valid || busy) seen++;
      @(negedge clk);
    end
    chk("midrst no_resp", seen, 0);
    chk("midrst counts", {rd_count, wr_count}, 0);
    do_txn(0, 32'h0000_3000, '0, 0, "midrst read", got);
    chk("midrst w0", got[31:0], 32'h0000_3000);

    for (int n = 0; n < 40; n++) begin
      a = ($urandom_range(0, 3) << 14) | ($urandom_range(0, 3) << 6)
          | $urandom_range(0, 63);
      if ($urandom_range(0, 1) == 1) a[31:24] = 8'hFF;
      for (int i = 0; i < 16; i++) wd[32*i +: 32] = $urandom;
      do_txn(1'($urandom), a, wd, $urandom_range(0, 3),
             $sformatf("rnd%0d", n), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
